// File: rtl/rtc_cal_pkg.sv
// rtl/rtc_cal_pkg.sv - calendar types, field/month constants and BCD/month-length helpers
package rtc_cal_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_APPLY,
        ST_WAIT_LOW
    } load_state_t;

    localparam logic [1:0] SEL_DAY   = 2'd0;
    localparam logic [1:0] SEL_MONTH = 2'd1;
    localparam logic [1:0] SEL_YEAR  = 2'd2;
    localparam logic [1:0] SEL_RSVD  = 2'd3;

    localparam logic [3:0] MONTH_JAN = 4'd1;
    localparam logic [3:0] MONTH_FEB = 4'd2;
    localparam logic [3:0] MONTH_APR = 4'd4;
    localparam logic [3:0] MONTH_JUN = 4'd6;
    localparam logic [3:0] MONTH_SEP = 4'd9;
    localparam logic [3:0] MONTH_NOV = 4'd11;
    localparam logic [3:0] MONTH_DEC = 4'd12;

    localparam int DAY_W   = 5;
    localparam int MONTH_W = 4;
    localparam int YEAR_W  = 7;

    // Only meaningful for 0..99, which covers every calendar field.
    function automatic logic [7:0] bin2bcd(input logic [7:0] v);
        return ((v / 8'd10) << 4) | (v % 8'd10);
    endfunction

    function automatic logic [7:0] bcd2bin(input logic [7:0] v);
        return ({4'd0, v[7:4]} * 8'd10) + {4'd0, v[3:0]};
    endfunction

    function automatic logic [DAY_W-1:0] days_in_month(input logic [MONTH_W-1:0] m, input logic leap);
        logic [DAY_W-1:0] len;
        case (m)
            MONTH_APR, MONTH_JUN, MONTH_SEP, MONTH_NOV: len = 5'd30;
            MONTH_FEB:                                  len = leap ? 5'd29 : 5'd28;
            default:                                    len = 5'd31;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/deco_dias_mes.sv
// rtl/deco_dias_mes.sv - combinational month + leap flag to month length (binary)
module deco_dias_mes
    import rtc_cal_pkg::*;
(
    input  logic [MONTH_W-1:0] month,
    input  logic               leap,
    output logic [DAY_W-1:0]   dias
);

    assign dias = days_in_month(month, leap);

endmodule

// File: rtl/rtc_date_counter.sv
// rtl/rtc_date_counter.sv - RTC day/month/year counter with leap-aware month length and validated field load
module rtc_date_counter
    import rtc_cal_pkg::*;
#(
    parameter int BCD_OUT   = 1,
    parameter int YEAR_SPAN = 100,
    parameter int DATA_W    = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Inc_day,
    input  logic              Load,
    input  logic [1:0]        Load_sel,
    input  logic [DATA_W-1:0] Load_dato,
    output logic              Load_ack,
    output logic              Load_err,
    output logic [DATA_W-1:0] Dia,
    output logic [DATA_W-1:0] Mes,
    output logic [DATA_W-1:0] Anio,
    output logic [DATA_W-1:0] Dias_mes,
    output logic              Anio_wrap
);

    load_state_t state, state_n;

    logic [DAY_W-1:0]   day, day_n, cur_len, cand_len, new_len;
    logic [MONTH_W-1:0] month, month_n, cand_month;
    logic [YEAR_W-1:0]  year, year_n, cand_year;
    logic [1:0]         cap_sel;
    logic [DATA_W-1:0]  cap_dato, val;
    logic               err_q, chk_err, bcd_bad;
    logic               pending, busy, drain, inc_do, wrap_n;

    function automatic logic [DATA_W-1:0] fmt(input logic [7:0] v);
        return (BCD_OUT != 0) ? DATA_W'(bin2bcd(v)) : DATA_W'(v);
    endfunction

    deco_dias_mes u_deco_cur (
        .month (month),
        .leap  (year[1:0] == 2'b00),
        .dias  (cur_len)
    );

    // Length of the month the date would land in if the captured load were applied.
    deco_dias_mes u_deco_cand (
        .month (cand_month),
        .leap  (cand_year[1:0] == 2'b00),
        .dias  (cand_len)
    );

    always_comb begin
        bcd_bad    = (BCD_OUT != 0) &&
                     (cap_dato[3:0] > 4'd9 || cap_dato[7:4] > 4'd9 || (cap_dato >> 8) != '0);
        val        = (BCD_OUT != 0) ? DATA_W'(bcd2bin(cap_dato[7:0])) : cap_dato;
        cand_month = (cap_sel == SEL_MONTH) ? val[MONTH_W-1:0] : month;
        cand_year  = (cap_sel == SEL_YEAR)  ? val[YEAR_W-1:0]  : year;
        chk_err    = bcd_bad;
        case (cap_sel)
            SEL_DAY:   if (val == '0 || val > DATA_W'(cur_len))   chk_err = 1'b1;
            SEL_MONTH: if (val == '0 || val > DATA_W'(MONTH_DEC)) chk_err = 1'b1;
            SEL_YEAR:  if (val >= DATA_W'(YEAR_SPAN))             chk_err = 1'b1;
            SEL_RSVD:  chk_err = 1'b1;
            default:   chk_err = 1'b1;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:     if (Load) state_n = ST_CHECK;
            ST_CHECK:    state_n = ST_APPLY;
            ST_APPLY:    state_n = ST_WAIT_LOW;
            ST_WAIT_LOW: if (!Load) state_n = ST_IDLE;
            default:     state_n = ST_IDLE;
        endcase
    end

    // A held-off increment drains once the date is no longer being validated or written.
    always_comb begin
        busy   = (state != ST_IDLE) || Load;
        drain  = pending && (state == ST_WAIT_LOW || (state == ST_IDLE && !Load));
        inc_do = drain || (Inc_day && state == ST_IDLE && !Load);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cap_sel  <= SEL_DAY;
            cap_dato <= '0;
            err_q    <= 1'b0;
            pending  <= 1'b0;
        end else begin
            if (state == ST_IDLE && Load) begin
                cap_sel  <= Load_sel;
                cap_dato <= Load_dato;
            end
            if (state == ST_CHECK) err_q <= chk_err;
            if (drain)               pending <= Inc_day && busy;
            else if (Inc_day && busy) pending <= 1'b1;
        end
    end

    always_comb begin
        day_n   = day;
        month_n = month;
        year_n  = year;
        wrap_n  = 1'b0;
        if (state == ST_APPLY && !err_q) begin
            case (cap_sel)
                SEL_DAY:   day_n   = val[DAY_W-1:0];
                SEL_MONTH: month_n = val[MONTH_W-1:0];
                SEL_YEAR:  year_n  = val[YEAR_W-1:0];
                default:   ;
            endcase
            if (day_n > cand_len) day_n = cand_len;
        end else if (inc_do) begin
            if (day < cur_len) begin
                day_n = day + 5'd1;
            end else begin
                day_n = 5'd1;
                if (month == MONTH_DEC) begin
                    month_n = MONTH_JAN;
                    if (year == YEAR_W'(YEAR_SPAN - 1)) begin
                        year_n = '0;
                        wrap_n = 1'b1;
                    end else begin
                        year_n = year + 7'd1;
                    end
                end else begin
                    month_n = month + 4'd1;
                end
            end
        end
        new_len = days_in_month(month_n, year_n[1:0] == 2'b00);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            day       <= 5'd1;
            month     <= MONTH_JAN;
            year      <= '0;
            Dia       <= fmt(8'd1);
            Mes       <= fmt(8'd1);
            Anio      <= fmt(8'd0);
            Dias_mes  <= fmt(8'd31);
            Load_ack  <= 1'b0;
            Load_err  <= 1'b0;
            Anio_wrap <= 1'b0;
        end else begin
            day       <= day_n;
            month     <= month_n;
            year      <= year_n;
            Dia       <= fmt(8'(day_n));
            Mes       <= fmt(8'(month_n));
            Anio      <= fmt(8'(year_n));
            Dias_mes  <= fmt(8'(new_len));
            Load_ack  <= (state == ST_APPLY);
            Load_err  <= (state == ST_APPLY) && err_q;
            Anio_wrap <= wrap_n;
        end
    end

endmodule
